// File: rtl/spi_pkg.sv
// Shared SPI definitions: the PISO transmit FSM states and the bit-order constants.
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  localparam logic LITTLE_END = 1'b0;
  localparam logic BIG_END    = 1'b1;

endpackage

// File: rtl/spi_piso_tx_if.sv
// Word-load handshake between the SPI master control and the PISO transmit shifter.
// A word transfers on a rising clk where TxValid && TxReady; TxData only matters in that cycle.
interface spi_piso_tx_if #(
  parameter int WordLen = 8
);

  logic [WordLen-1:0] TxData;
  logic               TxValid;
  logic               TxReady;

  modport master (
    output TxData,
    output TxValid,
    input  TxReady
  );

  modport slave (
    input  TxData,
    input  TxValid,
    output TxReady
  );

endinterface

// File: rtl/spi_tx_holdbuf.sv
// One-word holding register that queues the next transmit word while the shifter is busy.
module spi_tx_holdbuf #(
  parameter int WordLen = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               pop,
  input  logic [WordLen-1:0] data,
  output logic [WordLen-1:0] hold_data,
  output logic               hold_valid
);

  // load only happens while empty and pop only while full, so they never collide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
    end else if (load) begin
      hold_data  <= data;
      hold_valid <= 1'b1;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_piso_tx.sv
// SPI MOSI parallel-in/serial-out shifter with LSB/MSB-first order and word-done pulse.
// Define SPI_PISO_DBUF_EN to add a one-word holding register for gap-free back-to-back words.
module spi_piso_tx
  import spi_pkg::*;
#(
  parameter int WordLen = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         SCLKEdgeFlg,
  input  logic         EnPISO,
  input  logic         Endiannes,
  spi_piso_tx_if.slave tx,
  output logic         MOSI,
  output logic         Busy,
  output logic         WordDone,
  output piso_state_t  fsm_state
);

  localparam int                CntW   = $clog2(WordLen);
  localparam logic [CntW-1:0]   CntMax = CntW'(WordLen - 1);

  piso_state_t        state_q, state_d;
  logic [WordLen-1:0] sh_q, sh_d;
  logic               order_q, order_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               done_q, done_d;

  logic               take;
  logic               shift_ev;
  logic               reload;
  logic [WordLen-1:0] reload_data;

  assign take     = tx.TxValid && tx.TxReady;
  assign shift_ev = (state_q == SHIFT) && EnPISO && SCLKEdgeFlg;

`ifdef SPI_PISO_DBUF_EN
  logic               last;
  logic [WordLen-1:0] hold_data;
  logic               hold_valid;

  assign last = shift_ev && (cnt_q == '0);

  spi_tx_holdbuf #(.WordLen(WordLen)) u_holdbuf (
    .clk        (clk),
    .rst        (rst),
    .load       (take && (state_q == SHIFT) && !last),
    .pop        (last && hold_valid),
    .data       (tx.TxData),
    .hold_data  (hold_data),
    .hold_valid (hold_valid)
  );

  assign tx.TxReady = ~hold_valid;
  // On the final edge the queued word wins; with nothing queued a same-cycle transfer bypasses.
  assign reload      = hold_valid || take;
  assign reload_data = hold_valid ? hold_data : tx.TxData;
`else
  assign tx.TxReady  = (state_q == IDLE);
  assign reload      = 1'b0;
  assign reload_data = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      order_q <= LITTLE_END;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      order_q <= order_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    order_d = order_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (take) begin
          state_d = SHIFT;
          sh_d    = tx.TxData;
          order_d = Endiannes;
          cnt_d   = CntMax;
        end
      end
      SHIFT: begin
        if (shift_ev) begin
          if (cnt_q != '0) begin
            sh_d  = (order_q == BIG_END) ? (sh_q << 1) : (sh_q >> 1);
            cnt_d = cnt_q - CntW'(1);
          end else begin
            done_d = 1'b1;
            if (reload) begin
              sh_d    = reload_data;
              order_d = Endiannes;
              cnt_d   = CntMax;
            end else begin
              state_d = IDLE;
              sh_d    = '0;
              cnt_d   = '0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Busy      = (state_q == SHIFT);
  assign MOSI      = Busy && ((order_q == BIG_END) ? sh_q[WordLen-1] : sh_q[0]);
  assign WordDone  = done_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_spi_piso_tx.sv
// Directed bench for spi_piso_tx: bit order, pause, reset abort, word gap / back-to-back loading.
module tb_spi_piso_tx;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic SCLKEdgeFlg = 1'b0;
  logic EnPISO = 1'b1;
  logic Endiannes = 1'b0;
  logic MOSI, Busy, WordDone;
  piso_state_t fsm_state;

  int n_checks = 0;
  int n_pass   = 0;

  spi_piso_tx_if #(.WordLen(8)) tx_if ();

  spi_piso_tx #(.WordLen(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .SCLKEdgeFlg (SCLKEdgeFlg),
    .EnPISO      (EnPISO),
    .Endiannes   (Endiannes),
    .tx          (tx_if.slave),
    .MOSI        (MOSI),
    .Busy        (Busy),
    .WordDone    (WordDone),
    .fsm_state   (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_edge();
    SCLKEdgeFlg = 1'b1;
    @(posedge clk);
    #1;
    SCLKEdgeFlg = 1'b0;
  endtask

  task automatic load_word(input logic [7:0] data, input logic endian, input string name);
    check({name, "_ready"}, tx_if.TxReady, 1);
    tx_if.TxData  = data;
    tx_if.TxValid = 1'b1;
    Endiannes     = endian;
    idle_cycle();
    tx_if.TxValid = 1'b0;
    tx_if.TxData  = 8'($urandom_range(0, 255));
    check({name, "_busy"}, Busy, 1);
  endtask

  // seq[i] is the i-th bit expected on MOSI
  task automatic shift_word(input logic [7:0] seq, input bit toggle, input bit pause, input string name);
    check({name, "_b0"}, MOSI, seq[0]);
    for (int i = 1; i < 8; i++) begin
      if (toggle && i == 3) Endiannes = ~Endiannes;
      if (pause && i == 3) begin
        EnPISO = 1'b0;
        for (int c = 0; c < 5; c++) begin
          SCLKEdgeFlg = (c == 1 || c == 3);
          idle_cycle();
          SCLKEdgeFlg = 1'b0;
          check($sformatf("%s_pause%0d", name, c), MOSI, seq[2]);
        end
        EnPISO = 1'b1;
      end
      idle_cycle();
      check($sformatf("%s_hold%0d", name, i), MOSI, seq[i-1]);
`ifndef SPI_PISO_DBUF_EN
      if (i == 4) check({name, "_ready_busy"}, tx_if.TxReady, 0);
`endif
      pulse_edge();
      check($sformatf("%s_b%0d", name, i), MOSI, seq[i]);
      check($sformatf("%s_nodone%0d", name, i), WordDone, 0);
    end
    idle_cycle();
    pulse_edge();
    check({name, "_done"}, WordDone, 1);
    check({name, "_idle_busy"}, Busy, 0);
    check({name, "_idle_mosi"}, MOSI, 0);
  endtask

  initial begin
    logic [23:0] stream;
    tx_if.TxData  = '0;
    tx_if.TxValid = 1'b0;
    idle_cycle();
    idle_cycle();
    rst = 1'b0;
    idle_cycle();
    check("rst_mosi", MOSI, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", WordDone, 0);
    check("rst_ready", tx_if.TxReady, 1);
    check("rst_state", fsm_state, IDLE);

    // LSB-first 0xC1: 1,0,0,0,0,0,1,1
    load_word(8'hC1, LITTLE_END, "lsb");
    shift_word(8'b1100_0001, 1'b0, 1'b0, "lsb");
    idle_cycle();
    check("lsb_done_clear", WordDone, 0);
    check("lsb_state", fsm_state, IDLE);

    // MSB-first 0xC1: 1,1,0,0,0,0,0,1, Endiannes toggled mid-word
    load_word(8'hC1, BIG_END, "msb");
    shift_word(8'b1000_0011, 1'b1, 1'b0, "msb");
    idle_cycle();

    // Pause with ignored edges after the third bit
    load_word(8'hC1, LITTLE_END, "pause");
    shift_word(8'b1100_0001, 1'b0, 1'b1, "pause");
    idle_cycle();

    // Reset mid-word after 3 shift edges
    load_word(8'hC1, LITTLE_END, "abort");
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      pulse_edge();
    end
    #2 rst = 1'b1;
    #1;
    check("abort_mosi", MOSI, 0);
    check("abort_busy", Busy, 0);
    check("abort_ready", tx_if.TxReady, 1);
    check("abort_done", WordDone, 0);
    idle_cycle();
    check("abort_done_later", WordDone, 0);
    rst = 1'b0;
    idle_cycle();
    // 0x5A LSB-first: 0,1,0,1,1,0,1,0
    load_word(8'h5A, LITTLE_END, "after_rst");
    shift_word(8'b0101_1010, 1'b0, 1'b0, "after_rst");
    idle_cycle();

`ifndef SPI_PISO_DBUF_EN
    // TxValid held high: 0x34 only enters from IDLE after WordDone
    tx_if.TxData  = 8'h12;
    tx_if.TxValid = 1'b1;
    Endiannes     = LITTLE_END;
    idle_cycle();
    check("gap_w0_busy", Busy, 1);
    tx_if.TxData = 8'h34;
    shift_word(8'b0001_0010, 1'b0, 1'b0, "gap_w0");
    check("gap_ready", tx_if.TxReady, 1);
    idle_cycle();
    tx_if.TxValid = 1'b0;
    check("gap_accept", Busy, 1);
    check("gap_done_clear", WordDone, 0);
    shift_word(8'b0011_0100, 1'b0, 1'b0, "gap_w1");
    idle_cycle();
`else
    // Back-to-back 0x12, 0x34 (via hold) and 0x56 (bypass on final edge of 0x34)
    stream        = 24'h563412;
    tx_if.TxData  = 8'h12;
    tx_if.TxValid = 1'b1;
    Endiannes     = LITTLE_END;
    idle_cycle();
    tx_if.TxData = 8'h34;
    idle_cycle();
    tx_if.TxValid = 1'b0;
    check("dbuf_ready_drop", tx_if.TxReady, 0);
    check("dbuf_b0", MOSI, stream[0]);
    for (int e = 1; e <= 24; e++) begin
      idle_cycle();
      if (e == 16) begin
        check("dbuf_ready_bypass", tx_if.TxReady, 1);
        tx_if.TxValid = 1'b1;
        tx_if.TxData  = 8'h56;
      end
      pulse_edge();
      tx_if.TxValid = 1'b0;
      if (e < 24) begin
        check($sformatf("dbuf_b%0d", e), MOSI, stream[e]);
        check($sformatf("dbuf_busy%0d", e), Busy, 1);
      end
      check($sformatf("dbuf_done%0d", e), WordDone, (e % 8 == 0) ? 1 : 0);
    end
    check("dbuf_end_busy", Busy, 0);
    check("dbuf_end_mosi", MOSI, 0);
    idle_cycle();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
